// File: rtl/parameters.sv
// Shared definitions for the accumulator output stage.
//   ACC_DATA_WIDTH : default width of the adder-tree result and accumulator
//   state_t        : output-stage FSM state encoding
package parameters;

  localparam int ACC_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    SCALE  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/requant_unit.sv
// Combinational requantizer: round-half-up, arithmetic right shift, optional
// ReLU, then saturation to a signed OUT_DATA_WIDTH result.
// Optional feature macro: ACC_RELU_EN (negative results clamp to zero).
// Ports:
//   i_acc   : signed accumulator value, ACC_DATA_WIDTH bits
//   i_shift : right-shift amount (0..31)
//   o_data  : saturated requantized result, OUT_DATA_WIDTH bits
module requant_unit #(
  parameter int ACC_DATA_WIDTH = 32,
  parameter int OUT_DATA_WIDTH = 8
) (
  input  logic [ACC_DATA_WIDTH-1:0] i_acc,
  input  logic [4:0]                i_shift,
  output logic [OUT_DATA_WIDTH-1:0] o_data
);

  // One extra bit so the rounding add can never wrap.
  localparam int W = ACC_DATA_WIDTH + 1;

  localparam logic [OUT_DATA_WIDTH-1:0] OutMax = {1'b0, {(OUT_DATA_WIDTH-1){1'b1}}};
  localparam logic [OUT_DATA_WIDTH-1:0] OutMin = {1'b1, {(OUT_DATA_WIDTH-1){1'b0}}};

  logic signed [W-1:0] w_ext;
  logic signed [W-1:0] w_round;
  logic signed [W-1:0] w_sum;
  logic signed [W-1:0] w_shifted;
  logic signed [W-1:0] w_relu;
  logic [W-OUT_DATA_WIDTH:0] w_upper;
  logic w_fits;

  assign w_ext     = $signed({i_acc[ACC_DATA_WIDTH-1], i_acc});
  assign w_round   = (i_shift == 5'd0) ? '0 : (W'(1) << (i_shift - 5'd1));
  assign w_sum     = w_ext + w_round;
  assign w_shifted = w_sum >>> i_shift;

`ifdef ACC_RELU_EN
  assign w_relu = w_shifted[W-1] ? '0 : w_shifted;
`else
  assign w_relu = w_shifted;
`endif

  // Value fits the output when all bits from the output sign bit upward agree.
  assign w_upper = w_relu[W-1:OUT_DATA_WIDTH-1];
  assign w_fits  = (&w_upper) || ~(|w_upper);

  always_comb begin
    o_data = w_relu[OUT_DATA_WIDTH-1:0];
    if (!w_fits) begin
      o_data = w_relu[W-1] ? OutMin : OutMax;
    end
  end

endmodule

// File: rtl/acc_output_stage.sv
// Accumulator output stage: sums a group of signed adder-tree beats with
// saturation, then requantizes the sum and presents it on a valid/ready port.
// Optional feature macro: ACC_RELU_EN (handled inside requant_unit).
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   clear             : synchronous abort back to IDLE, drops any pending output
//   in_valid/in_ready : input beat handshake, in_data signed ACC_DATA_WIDTH
//   cfg_num_acc       : beats per output (0 means 1), latched on first beat
//   cfg_shift         : requantization right shift, latched on first beat
//   out_valid/out_ready, out_data : output handshake and requantized result
//   busy              : high whenever the FSM is not IDLE
module acc_output_stage #(
  parameter int ACC_DATA_WIDTH = parameters::ACC_DATA_WIDTH,
  parameter int OUT_DATA_WIDTH = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ACC_DATA_WIDTH-1:0] in_data,
  input  logic [CNT_WIDTH-1:0]      cfg_num_acc,
  input  logic [4:0]                cfg_shift,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_DATA_WIDTH-1:0] out_data,
  output logic                      busy
);

  import parameters::*;

  localparam logic [ACC_DATA_WIDTH-1:0] AccMax = {1'b0, {(ACC_DATA_WIDTH-1){1'b1}}};
  localparam logic [ACC_DATA_WIDTH-1:0] AccMin = {1'b1, {(ACC_DATA_WIDTH-1){1'b0}}};

  state_t                    r_state;
  logic [ACC_DATA_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0]      r_count;
  logic [CNT_WIDTH-1:0]      r_num_acc;
  logic [4:0]                r_shift;
  logic [OUT_DATA_WIDTH-1:0] r_out_data;
  logic                      r_out_valid;

  logic                      w_group_done;
  logic                      w_accept;
  logic [ACC_DATA_WIDTH:0]   w_wide_sum;
  logic [ACC_DATA_WIDTH-1:0] w_sat_sum;
  logic [OUT_DATA_WIDTH-1:0] w_requant;

  // The group completes one edge after the last beat lands; in_ready drops for
  // that cycle so no extra beat slips in, giving a uniform 2-cycle latency.
  assign w_group_done = (r_count == r_num_acc);
  assign in_ready     = (r_state == IDLE) || ((r_state == ACCUM) && !w_group_done);
  assign w_accept     = in_valid && in_ready;
  assign busy         = (r_state != IDLE);
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;

  // Saturating add: overflow when the two top bits of the widened sum differ.
  assign w_wide_sum = {r_acc[ACC_DATA_WIDTH-1], r_acc} + {in_data[ACC_DATA_WIDTH-1], in_data};

  always_comb begin
    w_sat_sum = w_wide_sum[ACC_DATA_WIDTH-1:0];
    if (w_wide_sum[ACC_DATA_WIDTH] != w_wide_sum[ACC_DATA_WIDTH-1]) begin
      w_sat_sum = w_wide_sum[ACC_DATA_WIDTH] ? AccMin : AccMax;
    end
  end

  requant_unit #(
    .ACC_DATA_WIDTH(ACC_DATA_WIDTH),
    .OUT_DATA_WIDTH(OUT_DATA_WIDTH)
  ) u_requant (
    .i_acc  (r_acc),
    .i_shift(r_shift),
    .o_data (w_requant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_num_acc   <= '0;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_num_acc <= (cfg_num_acc == '0) ? CNT_WIDTH'(1) : cfg_num_acc;
            r_shift   <= cfg_shift;
            r_acc     <= in_data;
            r_count   <= CNT_WIDTH'(1);
            r_state   <= ACCUM;
          end
        end
        ACCUM: begin
          if (w_group_done) begin
            r_state <= SCALE;
          end else if (w_accept) begin
            r_acc   <= w_sat_sum;
            r_count <= r_count + CNT_WIDTH'(1);
          end
        end
        SCALE: begin
          r_out_data  <= w_requant;
          r_out_valid <= 1'b1;
          r_state     <= OUTPUT;
        end
        OUTPUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_output_stage.sv
// Self-checking bench for acc_output_stage with a saturating-arithmetic
// reference model; honours ACC_RELU_EN when defined.
module tb_acc_output_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] cfg_num_acc;
  logic [4:0]  cfg_shift;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        busy;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  acc_output_stage dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .cfg_num_acc(cfg_num_acc),
    .cfg_shift  (cfg_shift),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: saturating 32-bit sum, round-half-up shift, optional ReLU,
  // clamp to signed 8 bits.
  function automatic int model_out(input int beats[$], input int shift);
    longint acc = 0;
    longint r;
    foreach (beats[i]) begin
      if (i == 0) acc = beats[i];
      else begin
        acc = acc + beats[i];
        if (acc > 64'sd2147483647) acc = 64'sd2147483647;
        if (acc < -64'sd2147483648) acc = -64'sd2147483648;
      end
    end
    r = acc;
    if (shift > 0) r = r + (64'sd1 << (shift - 1));
    r = r >>> shift;
`ifdef ACC_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return int'(r);
  endfunction

  // Offers each beat until accepted; config is scrambled after the first beat.
  // Returns at the negedge after the last accepting edge.
  task automatic drive_group(input int beats[$], input int num, input int shift,
                             input bit gaps, output int last_cyc, output bit to);
    int n;
    to = 1'b0;
    last_cyc = cyc;
    foreach (beats[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = beats[i];
      if (i == 0) begin
        cfg_num_acc = 16'(num);
        cfg_shift   = 5'(shift);
      end
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) begin
        to = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
      last_cyc    = cyc;
      in_valid    = 1'b0;
      cfg_num_acc = 16'($urandom);
      cfg_shift   = 5'($urandom);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int vcyc, output bit to);
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    to   = !out_valid;
    vcyc = cyc;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_num_acc = '0; cfg_shift = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
  endtask

  task automatic test_basic();
    int lc, vc;
    bit to, to2;
    out_ready = 1'b1;
    drive_group('{1, 2, 3, 4}, 4, 0, 1'b0, lc, to);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_after_last: in_ready %b out_valid %b want 0 0", in_ready, out_valid);
    end
    wait_out(vc, to2);
    checks++;
    if (to || to2) begin errors++; $display("FAIL basic_timeout: got timeout want handshake"); end
    checks++;
    if (vc - lc !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", vc - lc); end
    checks++;
    if ($signed(out_data) !== 8'sd10) begin errors++; $display("FAIL basic_data: got %0d want 10", $signed(out_data)); end
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL basic_output_state: busy %b in_ready %b want 1 0", busy, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL basic_hold1: out_valid %b busy %b in_ready %b want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  // Runs one group with out_ready high and checks the result value.
  task automatic test_directed(input string name, input int beats[$], input int num,
                               input int shift, input int expv);
    int lc, vc, got;
    bit to, to2;
    out_ready = 1'b1;
    drive_group(beats, num, shift, 1'b1, lc, to);
    wait_out(vc, to2);
    got = int'($signed(out_data));
    checks++;
    if (to || to2 || got !== expv || vc - lc !== 2) begin
      errors++;
      $display("FAIL %s: got %0d (latency %0d, timeout %b) want %0d (latency 2)", name, got, vc - lc,
               to | to2, expv);
    end
    @(negedge clk);
  endtask

  task automatic test_rounding();
    test_directed("round_pos", '{5, 1}, 2, 2, 2);
`ifdef ACC_RELU_EN
    test_directed("round_neg", '{-7, 0}, 2, 2, 0);
`else
    test_directed("round_neg", '{-7, 0}, 2, 2, -2);
`endif
  endtask

  task automatic test_saturation();
    test_directed("sat_out_hi", '{1000}, 1, 0, 127);
`ifdef ACC_RELU_EN
    test_directed("sat_out_lo", '{-1000}, 1, 0, 0);
`else
    test_directed("sat_out_lo", '{-1000}, 1, 0, -128);
`endif
    test_directed("sat_acc", '{32'h7FFFFFF0, 32'h100}, 2, 24, 127);
    test_directed("num_zero", '{37}, 0, 0, 37);
  endtask

  task automatic test_backpressure();
    int lc, vc;
    bit to, to2;
    logic [7:0] hold;
    out_ready = 1'b0;
    drive_group('{4, 4}, 2, 1, 1'b0, lc, to);
    wait_out(vc, to2);
    hold = out_data;
    checks++;
    if (to || to2 || hold !== 8'd4) begin errors++; $display("FAIL bp_data: got %0d want 4", hold); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd99;
      checks++;
      if (out_valid !== 1'b1 || out_data !== hold || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall%0d: out_valid %b data %0d in_ready %b want 1 %0d 0", i, out_valid,
                 out_data, in_ready, hold);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_release: out_valid %b busy %b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_clear_abort();
    int lc;
    int vc;
    bit to;
    bit to2;
    bit seen;
    out_ready = 1'b1;
    // clear after two of four beats
    drive_group('{5, 6}, 4, 0, 1'b0, lc, to);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL clear_idle: busy %b in_ready %b want 0 1", busy, in_ready);
    end
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL clear_no_output: got out_valid 1 want 0"); end
    test_directed("clear_regroup", '{3, 3, 3, 3}, 4, 0, 12);
    // reset after two of four beats
    drive_group('{100, -3}, 4, 0, 1'b0, lc, to);
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'd0) begin
      errors++; $display("FAIL reset_mid: busy %b out_valid %b data %0d want 0 0 0", busy, out_valid, out_data);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_no_output: got out_valid 1 want 0"); end
    test_directed("reset_regroup", '{3, 3, 3, 3}, 4, 0, 12);
    // clear while an output is pending drops it
    out_ready = 1'b0;
    drive_group('{9}, 1, 0, 1'b0, lc, to);
    wait_out(vc, to2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (to2 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL clear_output: out_valid %b busy %b want 0 0", out_valid, busy);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_random();
    int beats[$];
    int num, neff, shift, expv, got, lc, vc, k;
    bit to, to2;
    logic [7:0] hold;
    for (int g = 0; g < 30; g++) begin
      beats.delete();
      num   = $urandom_range(0, 5);
      neff  = (num == 0) ? 1 : num;
      shift = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
      for (int i = 0; i < neff; i++) begin
        if ($urandom_range(0, 2) == 0) beats.push_back(int'($urandom));
        else beats.push_back($urandom_range(0, 400) - 200);
      end
      expv = model_out(beats, shift);
      out_ready = 1'($urandom_range(0, 1));
      drive_group(beats, num, shift, 1'b1, lc, to);
      wait_out(vc, to2);
      got  = int'($signed(out_data));
      hold = out_data;
      checks++;
      if (to || to2 || got !== expv || vc - lc !== 2) begin
        errors++;
        $display("FAIL rand%0d: got %0d (latency %0d) want %0d (latency 2) num %0d shift %0d", g, got,
                 vc - lc, expv, num, shift);
      end
      if (!out_ready) begin
        k = $urandom_range(1, 3);
        repeat (k) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== hold) begin
          errors++; $display("FAIL rand_stall%0d: out_valid %b data %0d want 1 %0d", g, out_valid, out_data, hold);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rand_done%0d: out_valid %b busy %b want 0 0", g, out_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_backpressure();
    test_clear_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
